// File: rtl/sfu_result_collector.sv
// Pairs in-order SFU results with the opcodes of the operations that produced them,
// buffering results until the core takes them. Occupancy and sticky error flag are exported.
module sfu_result_collector #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [2:0]               selop_i,
    input  logic                     res_valid_i,
    input  logic [31:0]              res_data_i,
    output logic                     accept_o,
    output logic                     valid_o,
    output logic [31:0]              data_o,
    output logic [2:0]               selop_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2:0]    tag_mem [DEPTH];
    logic [2:0]    res_tag_mem [DEPTH];
    logic [31:0]   res_dat_mem [DEPTH];

    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [AW-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CW-1:0] tag_cnt_q, tag_cnt_d, res_cnt_q, res_cnt_d;
    logic          err_q, err_d;

    logic          issue, cap, pop;

    assign pending_o = tag_cnt_q + res_cnt_q;
    assign accept_o  = (pending_o < CW'(DEPTH));
    assign valid_o   = (res_cnt_q != '0);
    // Outputs read as zero while empty so reset and idle values are well defined.
    assign data_o    = valid_o ? res_dat_mem[res_rd_q] : '0;
    assign selop_o   = valid_o ? res_tag_mem[res_rd_q] : '0;
    assign err_o     = err_q;

    always_comb begin
        issue     = start_i & accept_o;
        cap       = res_valid_i & (tag_cnt_q != '0);
        pop       = valid_o & ready_i;

        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        res_wr_d  = res_wr_q;
        res_rd_d  = res_rd_q;

        if (issue) tag_wr_d = tag_wr_q + AW'(1);
        if (cap) begin
            tag_rd_d = tag_rd_q + AW'(1);
            res_wr_d = res_wr_q + AW'(1);
        end
        if (pop) res_rd_d = res_rd_q + AW'(1);

        tag_cnt_d = tag_cnt_q + CW'(issue) - CW'(cap);
        res_cnt_d = res_cnt_q + CW'(cap) - CW'(pop);

        err_d     = err_q | (start_i & ~accept_o) | (res_valid_i & (tag_cnt_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            tag_cnt_q <= '0;
            res_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            tag_cnt_q <= tag_cnt_d;
            res_cnt_q <= res_cnt_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: contents are only observable behind the occupancy counters.
    always_ff @(posedge clk) begin
        if (issue) tag_mem[tag_wr_q] <= selop_i;
        if (cap) begin
            res_tag_mem[res_wr_q] <= tag_mem[tag_rd_q];
            res_dat_mem[res_wr_q] <= res_data_i;
        end
    end

endmodule

// File: tb/tb_sfu_result_collector.sv
// Directed bench for sfu_result_collector: reset, single op, backpressure, simultaneous
// capture/pop at full occupancy, unexpected result, async reset mid-operation, wrap-around.
module tb_sfu_result_collector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  selop_i;
    logic        res_valid_i;
    logic [31:0] res_data_i;
    logic        accept_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic [2:0]  selop_o;
    logic        ready_i;
    logic [2:0]  pending_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    sfu_result_collector #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .selop_i(selop_i),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i), .accept_o(accept_o),
        .valid_o(valid_o), .data_o(data_o), .selop_o(selop_o), .ready_i(ready_i),
        .pending_o(pending_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 0; selop_i = 0; res_valid_i = 0; res_data_i = 0; ready_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 0; selop_i = 0; res_valid_i = 0; res_data_i = 0; ready_i = 0;
        #2;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
        n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data_o); end
        n_checks++; if (selop_o !== 3'd0) begin n_fail++; $display("FAIL reset_selop got=%0d exp=0", selop_o); end
        n_checks++; if (pending_o !== 3'd0) begin n_fail++; $display("FAIL reset_pending got=%0d exp=0", pending_o); end
        n_checks++; if (accept_o !== 1'b1) begin n_fail++; $display("FAIL reset_accept got=%0b exp=1", accept_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        do_reset();
    endtask

    task automatic test_single_op();
        start_i = 1; selop_i = 3'd2; ready_i = 1;
        step();
        start_i = 0;
        n_checks++; if (pending_o !== 3'd1) begin n_fail++; $display("FAIL single_pend0 got=%0d exp=1", pending_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid0 got=%0b exp=0", valid_o); end
        step();
        n_checks++; if (pending_o !== 3'd1) begin n_fail++; $display("FAIL single_pend1 got=%0d exp=1", pending_o); end
        res_valid_i = 1; res_data_i = 32'hDEADBEEF;
        step();
        res_valid_i = 0;
        n_checks++; if (pending_o !== 3'd1) begin n_fail++; $display("FAIL single_pend2 got=%0d exp=1", pending_o); end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid2 got=%0b exp=1", valid_o); end
        n_checks++; if (data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data got=%h exp=deadbeef", data_o); end
        n_checks++; if (selop_o !== 3'd2) begin n_fail++; $display("FAIL single_selop got=%0d exp=2", selop_o); end
        step();
        n_checks++; if (pending_o !== 3'd0) begin n_fail++; $display("FAIL single_pend3 got=%0d exp=0", pending_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid3 got=%0b exp=0", valid_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL single_err got=%0b exp=0", err_o); end
        ready_i = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] dat [4];
        dat[0] = 32'hAAAA_0001; dat[1] = 32'hBBBB_0002; dat[2] = 32'hCCCC_0003; dat[3] = 32'hDDDD_0004;
        do_reset();
        ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            start_i = 1; selop_i = 3'(i + 1);
            step();
        end
        start_i = 0;
        n_checks++; if (pending_o !== 3'd4) begin n_fail++; $display("FAIL bp_pend_full got=%0d exp=4", pending_o); end
        n_checks++; if (accept_o !== 1'b0) begin n_fail++; $display("FAIL bp_accept_full got=%0b exp=0", accept_o); end
        start_i = 1; selop_i = 3'd5;
        step();
        start_i = 0;
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL bp_err_overissue got=%0b exp=1", err_o); end
        n_checks++; if (pending_o !== 3'd4) begin n_fail++; $display("FAIL bp_pend_blocked got=%0d exp=4", pending_o); end
        for (int i = 0; i < 4; i++) begin
            res_valid_i = 1; res_data_i = dat[i];
            step();
        end
        res_valid_i = 0;
        n_checks++; if (pending_o !== 3'd4) begin n_fail++; $display("FAIL bp_pend_buffered got=%0d exp=4", pending_o); end
        ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d got=%0b exp=1", i, valid_o); end
            n_checks++; if (data_o !== dat[i]) begin n_fail++; $display("FAIL bp_data%0d got=%h exp=%h", i, data_o, dat[i]); end
            n_checks++; if (selop_o !== 3'(i + 1)) begin n_fail++; $display("FAIL bp_selop%0d got=%0d exp=%0d", i, selop_o, i + 1); end
            step();
        end
        ready_i = 0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drained_valid got=%0b exp=0", valid_o); end
        n_checks++; if (pending_o !== 3'd0) begin n_fail++; $display("FAIL bp_drained_pend got=%0d exp=0", pending_o); end
        n_checks++; if (accept_o !== 1'b1) begin n_fail++; $display("FAIL bp_drained_accept got=%0b exp=1", accept_o); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] dat [4];
        logic [2:0]  sel [4];
        dat[0] = 32'h1111_1111; dat[1] = 32'h2222_2222; dat[2] = 32'h3333_3333; dat[3] = 32'h4444_4444;
        sel[0] = 3'd5; sel[1] = 3'd6; sel[2] = 3'd7; sel[3] = 3'd0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            start_i = 1; selop_i = sel[i];
            step();
        end
        start_i = 0;
        for (int i = 0; i < 3; i++) begin
            res_valid_i = 1; res_data_i = dat[i];
            step();
        end
        res_valid_i = 0;
        n_checks++; if (accept_o !== 1'b0) begin n_fail++; $display("FAIL sim_accept_full got=%0b exp=0", accept_o); end
        start_i = 1; selop_i = 3'd1;
        step();
        start_i = 0;
        n_checks++; if (pending_o !== 3'd4) begin n_fail++; $display("FAIL sim_pend_blocked got=%0d exp=4", pending_o); end
        res_valid_i = 1; res_data_i = dat[3]; ready_i = 1;
        n_checks++; if (data_o !== dat[0]) begin n_fail++; $display("FAIL sim_head0 got=%h exp=%h", data_o, dat[0]); end
        step();
        res_valid_i = 0;
        n_checks++; if (pending_o !== 3'd3) begin n_fail++; $display("FAIL sim_pend_after got=%0d exp=3", pending_o); end
        n_checks++; if (accept_o !== 1'b1) begin n_fail++; $display("FAIL sim_accept_after got=%0b exp=1", accept_o); end
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (data_o !== dat[i]) begin n_fail++; $display("FAIL sim_data%0d got=%h exp=%h", i, data_o, dat[i]); end
            n_checks++; if (selop_o !== sel[i]) begin n_fail++; $display("FAIL sim_selop%0d got=%0d exp=%0d", i, selop_o, sel[i]); end
            step();
        end
        ready_i = 0;
        n_checks++; if (pending_o !== 3'd0) begin n_fail++; $display("FAIL sim_drained_pend got=%0d exp=0", pending_o); end
    endtask

    task automatic test_unexpected();
        do_reset();
        res_valid_i = 1; res_data_i = 32'h5A5A_5A5A;
        step();
        res_valid_i = 0;
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL unexp_err got=%0b exp=1", err_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL unexp_valid got=%0b exp=0", valid_o); end
        n_checks++; if (pending_o !== 3'd0) begin n_fail++; $display("FAIL unexp_pend got=%0d exp=0", pending_o); end
        step();
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL unexp_sticky got=%0b exp=1", err_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            start_i = 1; selop_i = 3'(i + 3);
            step();
        end
        start_i = 0;
        res_valid_i = 1; res_data_i = 32'h7777_0000;
        step();
        res_valid_i = 0;
        n_checks++; if (pending_o !== 3'd3) begin n_fail++; $display("FAIL mid_pend_pre got=%0d exp=3", pending_o); end
        #3 rst = 1'b1;
        #1;
        n_checks++; if (pending_o !== 3'd0) begin n_fail++; $display("FAIL mid_pend got=%0d exp=0", pending_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%0b exp=0", valid_o); end
        n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL mid_data got=%h exp=0", data_o); end
        n_checks++; if (accept_o !== 1'b1) begin n_fail++; $display("FAIL mid_accept got=%0b exp=1", accept_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%0b exp=0", err_o); end
        @(posedge clk);
        #1 rst = 1'b0;
        test_single_op();
    endtask

    task automatic test_wrap();
        int          sfu_ret[$];
        logic [31:0] sfu_dat[$];
        logic [31:0] exp_dat[$];
        logic [2:0]  exp_sel[$];
        int          n_ops, issued, delivered, last_ret, c, r;
        logic [31:0] ed;
        logic [2:0]  es;
        n_ops = 3 * DEPTH + 1; issued = 0; delivered = 0; last_ret = 0; c = 0;
        do_reset();
        ready_i = 1;
        while (delivered < n_ops && c < 400) begin
            if (valid_o === 1'b1) begin
                if (exp_dat.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL wrap_spurious data=%h", data_o);
                end else begin
                    ed = exp_dat.pop_front(); es = exp_sel.pop_front();
                    n_checks++; if (data_o !== ed) begin n_fail++; $display("FAIL wrap_data%0d got=%h exp=%h", delivered, data_o, ed); end
                    n_checks++; if (selop_o !== es) begin n_fail++; $display("FAIL wrap_selop%0d got=%0d exp=%0d", delivered, selop_o, es); end
                end
                delivered++;
            end
            res_valid_i = 0;
            if (sfu_ret.size() != 0 && sfu_ret[0] == c) begin
                r = sfu_ret.pop_front();
                res_valid_i = 1; res_data_i = sfu_dat.pop_front();
            end
            start_i = 0;
            if (issued < n_ops && accept_o === 1'b1) begin
                start_i = 1; selop_i = 3'(issued);
                r = c + 1 + int'($urandom_range(0, 3));
                if (r <= last_ret) r = last_ret + 1;
                last_ret = r;
                sfu_ret.push_back(r);
                sfu_dat.push_back(32'hC0DE_0000 + 32'(issued));
                exp_dat.push_back(32'hC0DE_0000 + 32'(issued));
                exp_sel.push_back(3'(issued));
                issued++;
            end
            step();
            c++;
        end
        start_i = 0; res_valid_i = 0;
        n_checks++; if (delivered != n_ops) begin n_fail++; $display("FAIL wrap_count got=%0d exp=%0d", delivered, n_ops); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wrap_err got=%0b exp=0", err_o); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_simultaneous();
        test_unexpected();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
